window_gen_5x5: RTL
===================

# window_gen_5x5

Raster-to-window generator feeding the 5x5 Gaussian convolution stage. It accepts one pixel per cycle in raster order, buffers the four previous image rows in line memories, and presents a full 5x5 neighbourhood plus its centre coordinate whenever that neighbourhood lies entirely inside the frame. It is the producer side of the convolution's `window_in[0:24]` interface and sits between the pixel source and the convolver.

## Interface
- `DATA_WIDTH`, 8, pixel width in bits
- `IMG_WIDTH`, 640, pixels per line (≥5)
- `IMG_HEIGHT`, 480, lines per frame (≥5)
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `pix_valid`  in  1  `pix_in` carries a pixel this cycle
- `sof`  in  1  start of frame; qualified by `pix_valid`; marks the pixel as (0,0)
- `pix_in`  in  DATA_WIDTH  input pixel
- `window_out[0:24]`  out  DATA_WIDTH each  unpacked array, row-major, index r*5+c; r=0 top/oldest row, c=0 left/oldest column
- `window_valid`  out  1  `window_out` holds a complete in-frame neighbourhood
- `center_x`  out  $clog2(IMG_WIDTH)  column of window centre (element 12)
- `center_y`  out  $clog2(IMG_HEIGHT)  row of window centre
- `frame_done`  out  1  one-cycle pulse with the last window of a frame

## Operation
- Counters x (column) and y (row) hold the position of the next accepted pixel. They advance only when `pix_valid`=1.
- `pix_valid`=0 cycles freeze all state. No backpressure exists.
- On acceptance at (x,y):
  - New column = {lb3[x], lb2[x], lb1[x], lb0[x], pix_in}, which are rows y-4 .. y.
  - Line buffers shift in place: lb3[x]←lb2[x], lb2[x]←lb1[x], lb1[x]←lb0[x], lb0[x]←pix_in.
  - Each buffer has depth IMG_WIDTH and uses one read and one write per accepted pixel at the same address.
- Window register is 5x5. On acceptance, columns shift left (column c←c+1) and the new column loads column 4, top to bottom.
- Validity: `window_valid`←1 iff the accepted pixel has x≥4 and y≥4. Otherwise it is 0.
- Only valid-convolution windows are produced, with no padding: (IMG_WIDTH-4)×(IMG_HEIGHT-4) windows per frame.
- Coordinates: `center_x`←x-2, `center_y`←y-2, registered with the window.
- Wrap-around:
  - x=IMG_WIDTH-1 → x←0, y←y+1.
  - Additionally at y=IMG_HEIGHT-1 → y←0, and `frame_done`←1 in the same update as the final window.
- `sof` with `pix_valid`: the pixel is treated as (0,0) regardless of the counters, and counting continues from there. Window and line buffer contents are not cleared, because validity gating masks stale data.
- `sof` without `pix_valid` is ignored.
- Stale window columns at x<4 and stale line-buffer rows at y<4 never reach a valid output.

## Timing
- Latency is 1 cycle: outputs update on the clock edge that accepts the pixel, so they are visible the following cycle.
- `window_valid` and `frame_done` are single-cycle per accepted pixel. They drop to 0 on the next edge if `pix_valid`=0 or the new pixel is out of range.
- `window_out`, `center_x` and `center_y` hold their values while `pix_valid`=0.
- Reset values:
  - `window_out` all 0, `window_valid` 0, `center_x` 0, `center_y` 0, `frame_done` 0.
  - x=0, y=0.
  - Line-buffer contents are undefined and not reset.
- Reset mid-frame: outputs clear immediately (asynchronous). The next accepted pixel is (0,0) whether or not `sof` is asserted.
- Sustained throughput is one pixel per cycle with no bubbles, including across line and frame boundaries.

## Test plan
Common setup for all scenarios: IMG_WIDTH=8, IMG_HEIGHT=6, DATA_WIDTH=8, pixel value = y*16+x.
- **Continuous frame:** `sof` on the first pixel, 48 back-to-back pixels → exactly 8 windows.
  - First window appears the cycle after (4,4): `window_out[0]`=0x00, [12]=0x22, [24]=0x44, `center`=(2,2).
  - Last window: [24]=0x57, `center`=(5,3), `frame_done`=1 on that cycle only.
- **Random `pix_valid` gaps (~50%):** window contents and order are identical to the continuous run; outputs hold during gaps; `window_valid` is never high in a gap cycle after the first.
- **Back-to-back frames:** a second frame follows with no idle cycle → the second frame also yields 8 windows. The first window of frame 2 has [24]=0x44 and contains no frame-1 data.
- **`sof` resync:** `sof` is asserted at pixel (3,2) of the current count → that pixel is treated as (0,0). No window is produced until 36 further pixels have been accepted. `frame_done` follows exactly 48 pixels after the resync.
- **Reset mid-frame:** `rst_n` is pulsed low at pixel (6,4) → all outputs read 0 during reset. A restarted frame without `sof` produces the same 8 windows as the first scenario.

Source files
------------

// File: rtl/window_gen_5x5.sv
// -----------------------------------------------------------------------------
// window_gen_5x5
//
// Raster-to-window generator for the 5x5 Gaussian convolver. Pixels arrive one
// per cycle in raster order. Four line memories hold the previous four rows, so
// every accepted pixel completes one 5-pixel column (rows y-4 .. y). That column
// is shifted into a 5x5 window register. The window is flagged valid only when
// it lies entirely inside the frame (x>=4 and y>=4). No padding is applied.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   pix_valid     pix_in carries a pixel this cycle
//   sof           start of frame, qualified by pix_valid; the pixel becomes (0,0)
//   pix_in        input pixel
//   window_out    25 pixels, row-major (r*5+c); r=0 oldest row, c=0 oldest col
//   window_valid  window_out holds a complete in-frame neighbourhood
//   center_x      column of the window centre (element 12)
//   center_y      row of the window centre
//   frame_done    one-cycle pulse together with the last window of a frame
//
// Latency is one cycle from the accepting edge. Idle cycles (pix_valid=0)
// freeze all state. Valid and frame_done pulses drop on the next edge.
// -----------------------------------------------------------------------------
module window_gen_5x5 #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pix_valid,
  input  logic                          sof,
  input  logic [DATA_WIDTH-1:0]         pix_in,
  output logic [DATA_WIDTH-1:0]         window_out [0:24],
  output logic                          window_valid,
  output logic [$clog2(IMG_WIDTH)-1:0]  center_x,
  output logic [$clog2(IMG_HEIGHT)-1:0] center_y,
  output logic                          frame_done
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
  localparam logic [XW-1:0] X_ONE  = XW'(1);
  localparam logic [YW-1:0] Y_ONE  = YW'(1);
  localparam logic [XW-1:0] X_TWO  = XW'(2);
  localparam logic [YW-1:0] Y_TWO  = YW'(2);
  localparam logic [XW-1:0] X_EDGE = XW'(4);
  localparam logic [YW-1:0] Y_EDGE = YW'(4);

  // Position of the next pixel to be accepted.
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;

  // Line memories: lb0 holds row y-1, lb3 holds row y-4 (at the current column).
  logic [DATA_WIDTH-1:0] lb0 [0:IMG_WIDTH-1];
  logic [DATA_WIDTH-1:0] lb1 [0:IMG_WIDTH-1];
  logic [DATA_WIDTH-1:0] lb2 [0:IMG_WIDTH-1];
  logic [DATA_WIDTH-1:0] lb3 [0:IMG_WIDTH-1];

  logic                  accept_p0;
  logic [XW-1:0]         cur_x_p0;
  logic [YW-1:0]         cur_y_p0;
  logic [DATA_WIDTH-1:0] col_p0 [0:4];
  logic                  vld_p0;
  logic                  last_p0;

  // The accepted pixel sits inside a full 5x5 neighbourhood once four earlier
  // rows and four earlier columns exist.
  function automatic logic in_frame(input logic [XW-1:0] px, input logic [YW-1:0] py);
    return (px >= X_EDGE) && (py >= Y_EDGE);
  endfunction

  function automatic logic is_last(input logic [XW-1:0] px, input logic [YW-1:0] py);
    return (px == X_LAST) && (py == Y_LAST);
  endfunction

  // ---- stage p0: position resolution and column assembly ----
  always_comb begin
    accept_p0 = pix_valid;
    // sof forces the pixel to (0,0); counting continues from that point.
    cur_x_p0  = sof ? '0 : x_cnt;
    cur_y_p0  = sof ? '0 : y_cnt;
    col_p0[0] = lb3[cur_x_p0];
    col_p0[1] = lb2[cur_x_p0];
    col_p0[2] = lb1[cur_x_p0];
    col_p0[3] = lb0[cur_x_p0];
    col_p0[4] = pix_in;
    vld_p0    = accept_p0 && in_frame(cur_x_p0, cur_y_p0);
    last_p0   = accept_p0 && is_last(cur_x_p0, cur_y_p0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (accept_p0) begin
      if (cur_x_p0 == X_LAST) begin
        x_cnt <= '0;
        y_cnt <= (cur_y_p0 == Y_LAST) ? '0 : cur_y_p0 + Y_ONE;
      end else begin
        x_cnt <= cur_x_p0 + X_ONE;
        y_cnt <= cur_y_p0;
      end
    end
  end

  // Line memories are not reset. Stale rows are never exposed because the
  // validity gate needs four complete rows of the current frame first.
  // One read and one write per accepted pixel, both at the same column.
  always_ff @(posedge clk) begin
    if (accept_p0) begin
      lb3[cur_x_p0] <= lb2[cur_x_p0];
      lb2[cur_x_p0] <= lb1[cur_x_p0];
      lb1[cur_x_p0] <= lb0[cur_x_p0];
      lb0[cur_x_p0] <= pix_in;
    end
  end

  // ---- stage p1: window register and registered outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 25; i++) begin
        window_out[i] <= '0;
      end
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      center_x     <= '0;
      center_y     <= '0;
    end else begin
      window_valid <= vld_p0;
      frame_done   <= last_p0;
      if (accept_p0) begin
        for (int r = 0; r < 5; r++) begin
          for (int c = 0; c < 4; c++) begin
            window_out[r*5+c] <= window_out[r*5+c+1];
          end
          window_out[r*5+4] <= col_p0[r];
        end
        // Only meaningful while window_valid; earlier columns wrap harmlessly.
        center_x <= cur_x_p0 - X_TWO;
        center_y <= cur_y_p0 - Y_TWO;
      end
    end
  end

endmodule
